// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the 16-bit XNOR LFSR generator/checker pair:
// tap positions, lock-up pattern, checker states and the feedback function.
package lfsr_checker_pkg;

  localparam int LFSR_W = 16;
  localparam int TAP0   = 0;
  localparam int TAP1   = 1;
  localparam int TAP2   = 3;
  localparam int TAP3   = 12;

  // All-ones is the one self-consistent pattern of an XNOR LFSR.
  localparam logic [LFSR_W-1:0] LOCKUP = 16'hFFFF;

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} chk_state_t;

  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] s);
    return ~(s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3]);
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Serial bit stream and status bundle between a stream source and the
// LFSR checker.
interface lfsr_checker_if #(
  parameter int CNT_W = 16
);
  logic             bit_in;
  logic             bit_valid;
  logic             clear_counts;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output bit_in, bit_valid, clear_counts,
    input  locked, err_pulse, err_count, bit_count
  );

  modport slave (
    input  bit_in, bit_valid, clear_counts,
    output locked, err_pulse, err_count, bit_count
  );
endinterface

// File: rtl/lfsr_checker_predict.sv
// History register and next-bit predictor; in flywheel mode the register
// follows its own prediction so a corrupted input bit does not poison it.
module lfsr_checker_predict
  import lfsr_checker_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              shift_en,
  input  logic              use_pred,
  output logic [LFSR_W-1:0] hist,
  output logic              pred
);

  logic in_bit;

  assign pred   = lfsr_feedback(hist);
  assign in_bit = use_pred ? pred : bit_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
    end else if (shift_en) begin
      hist <= {in_bit, hist[LFSR_W-1:1]};
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 16-bit XNOR LFSR stream: hunts, verifies,
// locks, and counts mismatches with a windowed error density loss-of-lock rule.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int LOCK_COUNT = 32,
  parameter int WIN        = 64,
  parameter int ERR_LIMIT  = 4,
  parameter int CNT_W      = 16
) (
  input logic           clk,
  input logic           rst,
  lfsr_checker_if.slave bus
);

  localparam int FILL_W = $clog2(LFSR_W);
  localparam int RUN_W  = $clog2(LOCK_COUNT);
  localparam int WIN_W  = $clog2(WIN);
  localparam int ERR_W  = $clog2(ERR_LIMIT + 1);

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LFSR_W - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN - 1);
  localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'(ERR_LIMIT - 1);

  chk_state_t        state;
  logic [FILL_W-1:0] fill;
  logic [RUN_W-1:0]  run;
  logic [WIN_W-1:0]  win_cnt;
  logic [ERR_W-1:0]  win_err;
  logic              locked;
  logic              err_pulse;
  logic [CNT_W-1:0]  err_count;
  logic [CNT_W-1:0]  bit_count;

  logic [LFSR_W-1:0] hist;
  logic              pred;
  logic              mismatch;
  logic              lockup;

  lfsr_checker_predict u_predict (
    .clk      (clk),
    .rst      (rst),
    .bit_in   (bus.bit_in),
    .shift_en (bus.bit_valid),
    .use_pred (state == LOCKED),
    .hist     (hist),
    .pred     (pred)
  );

  assign mismatch = bus.bit_in ^ pred;
  assign lockup   = (hist == LOCKUP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      fill      <= '0;
      run       <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (bus.bit_valid) begin
        unique case (state)
          HUNT: begin
            if (fill == FILL_LAST) begin
              state <= CHECK;
              fill  <= '0;
              run   <= '0;
            end else begin
              fill <= fill + FILL_W'(1);
            end
          end
          CHECK: begin
            if (lockup) begin
              state <= HUNT;
              fill  <= '0;
            end else if (mismatch) begin
              run       <= '0;
              err_pulse <= 1'b1;
            end else if (run == RUN_LAST) begin
              state   <= LOCKED;
              locked  <= 1'b1;
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              run <= run + RUN_W'(1);
            end
          end
          LOCKED: begin
            if (lockup) begin
              state  <= HUNT;
              locked <= 1'b0;
              fill   <= '0;
            end else begin
              err_pulse <= mismatch;
              // Reaching the limit wins over a window boundary on the same bit.
              if (mismatch && (win_err == ERR_LAST)) begin
                state  <= HUNT;
                locked <= 1'b0;
                fill   <= '0;
              end
              if (win_cnt == WIN_LAST) begin
                win_cnt <= '0;
                win_err <= '0;
              end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                if (mismatch) begin
                  win_err <= win_err + ERR_W'(1);
                end
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
            fill   <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      bit_count <= '0;
    end else if (bus.clear_counts) begin
      err_count <= '0;
      bit_count <= '0;
    end else if (bus.bit_valid && (state == LOCKED) && !lockup) begin
      if (bit_count != '1) begin
        bit_count <= bit_count + CNT_W'(1);
      end
      if (mismatch && (err_count != '1)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

  assign bus.locked    = locked;
  assign bus.err_pulse = err_pulse;
  assign bus.err_count = err_count;
  assign bus.bit_count = bit_count;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: stimulus queues expected outputs per
// driven cycle, a negedge monitor pops and compares them when they fall due.
module tb_lfsr_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_checker_if #(.CNT_W(16)) bus ();

  lfsr_checker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          due;
    string       name;
    logic        lk;
    logic        ep;
    logic [15:0] ec;
    logic [15:0] bc;
  } exp_t;

  exp_t        sb[$];
  int          cyc      = 0;
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] gs       = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference generator: S <= {f, S[15:1]}, f = ~(S0^S1^S3^S12), output S0.
  task automatic gen_bit(output logic b);
    logic f;
    b  = gs[0];
    f  = ~(gs[0] ^ gs[1] ^ gs[3] ^ gs[12]);
    gs = {f, gs[15:1]};
  endtask

  task automatic checkOutput(input string name, input logic lk, input logic ep,
                             input logic [15:0] ec, input logic [15:0] bc);
    checks++;
    if ({bus.locked, bus.err_pulse, bus.err_count, bus.bit_count} !== {lk, ep, ec, bc}) begin
      failures++;
      $display("[TB] FAIL %s: got locked=%0b err_pulse=%0b err_count=%0d bit_count=%0d, expected locked=%0b err_pulse=%0b err_count=%0d bit_count=%0d",
               name, bus.locked, bus.err_pulse, bus.err_count, bus.bit_count, lk, ep, ec, bc);
    end
  endtask

  task automatic applyStimulus(input string name, input logic b, input logic v, input logic clr,
                               input logic lk, input logic ep,
                               input logic [15:0] ec, input logic [15:0] bc);
    exp_t e;
    @(posedge clk);
    #1;
    bus.bit_in       = b;
    bus.bit_valid    = v;
    bus.clear_counts = clr;
    e.due  = cyc + 1;
    e.name = name;
    e.lk   = lk;
    e.ep   = ep;
    e.ec   = ec;
    e.bc   = bc;
    sb.push_back(e);
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    bus.bit_valid    = 1'b0;
    bus.clear_counts = 1'b0;
    for (int t = 0; t < 8 && sb.size() > 0; t++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic doReset();
    drain();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    gs  = 16'h0000;
  endtask

  function automatic logic is_flip(input int i);
    case (i)
      520, 630, 640, 650, 700, 720, 725, 730, 800: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checkOutput(e.name, e.lk, e.ep, e.ec, e.bc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic        b, f, lk;
    logic [15:0] ec, bc;
    int          nflip, n;

    bus.bit_in       = 1'b0;
    bus.bit_valid    = 1'b0;
    bus.clear_counts = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset state", 1'b0, 1'b0, 16'd0, 16'd0);

    // Long clean stream with single error, windowed errors, unlock, relock, clear.
    nflip = 0;
    for (int i = 0; i <= 850; i++) begin
      gen_bit(b);
      f = is_flip(i);
      if (f) nflip++;
      lk = ((i >= 47) && (i < 730)) || (i >= 778);
      ec = (i >= 800) ? 16'd0 : 16'(nflip);
      if (i <= 47)       bc = 16'd0;
      else if (i <= 730) bc = 16'(i - 47);
      else if (i <= 778) bc = 16'd683;
      else if (i < 800)  bc = 16'(683 + (i - 778));
      else               bc = 16'(i - 800);
      applyStimulus($sformatf("stream bit %0d", i), b ^ f, 1'b1, (i == 800), lk, f, ec, bc);
    end

    // Async reset between clock edges while locked.
    drain();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async reset while locked", 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    gs  = 16'h0000;
    for (int i = 0; i < 60; i++) begin
      gen_bit(b);
      applyStimulus($sformatf("relock bit %0d", i), b, 1'b1, 1'b0, (i >= 47), 1'b0,
                    16'd0, (i <= 47) ? 16'd0 : 16'(i - 47));
    end

    // bit_valid toggling: lock after 48 valid bits, stalls change nothing.
    doReset();
    n = 0;
    for (int c = 0; c < 96; c++) begin
      if ((c % 2) == 0) begin
        gen_bit(b);
        n++;
        applyStimulus($sformatf("toggle cyc %0d", c), b, 1'b1, 1'b0, (n >= 48), 1'b0, 16'd0, 16'd0);
      end else begin
        applyStimulus($sformatf("toggle cyc %0d", c), 1'(c / 2), 1'b0, 1'b0, (n >= 48), 1'b0, 16'd0, 16'd0);
      end
    end
    for (int c = 0; c < 6; c++) begin
      applyStimulus($sformatf("stall %0d", c), 1'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
    end
    for (int c = 0; c < 4; c++) begin
      gen_bit(b);
      applyStimulus($sformatf("after stall %0d", c), b, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 16'(c + 1));
    end

    // Stuck-at-1 input never locks and never flags.
    doReset();
    for (int i = 0; i < 200; i++) begin
      applyStimulus($sformatf("stuck1 bit %0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    end

    // Stuck-at-0 input mismatches on every CHECK bit.
    doReset();
    for (int i = 0; i < 200; i++) begin
      applyStimulus($sformatf("stuck0 bit %0d", i), 1'b0, 1'b1, 1'b0, 1'b0, (i >= 16), 16'd0, 16'd0);
    end

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
